// File: rtl/codec_cfg_pkg.sv
// Shared types and the codec power-up register table.
// Used by codec_config_sequencer and codec_cfg_byte_mux.
package codec_cfg_pkg;

    localparam logic [6:0] CODEC_I2C_ADDR = 7'h1A;

    typedef struct packed {
        logic [6:0] addr;
        logic [8:0] data;
    } codec_reg_t;

    // Unused tail entries repeat the harmless reset write.
    localparam codec_reg_t CODEC_CFG_TABLE [16] = '{
        '{7'd15, 9'h000},
        '{7'd2,  9'h079},
        '{7'd3,  9'h079},
        '{7'd4,  9'h010},
        '{7'd5,  9'h000},
        '{7'd6,  9'h067},
        '{7'd7,  9'h002},
        '{7'd8,  9'h000},
        '{7'd9,  9'h001},
        '{7'd15, 9'h000},
        '{7'd15, 9'h000},
        '{7'd15, 9'h000},
        '{7'd15, 9'h000},
        '{7'd15, 9'h000},
        '{7'd15, 9'h000},
        '{7'd15, 9'h000}
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_ACK,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } cfg_state_e;

endpackage

// File: rtl/codec_cfg_byte_mux.sv
// Maps table index and byte position to the I2C byte
// and its START/STOP command flags (combinational).
module codec_cfg_byte_mux
    import codec_cfg_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = CODEC_I2C_ADDR
) (
    input  logic [3:0] index,
    input  logic [1:0] byte_sel,
    output logic [7:0] byte_out,
    output logic       cmd_start,
    output logic       cmd_stop
);

    codec_reg_t entry;

    // Select address byte, register/data-MSB byte or data-LSB byte.
    always_comb begin
        entry     = CODEC_CFG_TABLE[index];
        byte_out  = 8'h00;
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        unique case (1'b1)
            (byte_sel == 2'd0): begin
                byte_out  = {DEV_ADDR, 1'b0};
                cmd_start = 1'b1;
            end
            (byte_sel == 2'd1): begin
                byte_out = {entry.addr, entry.data[8]};
            end
            default: begin
                byte_out = entry.data[7:0];
                cmd_stop = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/codec_config_sequencer.sv
// Walks the codec register table over the I2C byte engine.
// Optional NACK retry: define CODEC_CFG_RETRY_EN.
module codec_config_sequencer
    import codec_cfg_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = CODEC_I2C_ADDR,
    parameter int          NUM_REGS    = 9,
    parameter logic [15:0] GAP_CYCLES  = 16'd1000,
    parameter int          MAX_RETRIES = 3
) (
    input  logic       i_CLK,
    input  logic       i_NRESET,
    input  logic       i_START,
    output logic       o_REQ,
    output logic       o_CMD_START,
    output logic       o_CMD_STOP,
    output logic [7:0] o_BYTE,
    input  logic       i_ACK,
    input  logic       i_NACK,
    output logic       o_BUSY,
    output logic       o_CODEC_READY,
    output logic       o_ERROR,
    output logic [3:0] o_INDEX
);

    if (NUM_REGS < 1 || NUM_REGS > 16 || MAX_RETRIES < 0) begin : g_bad_param
        $error("codec_config_sequencer: parameter out of range");
    end

    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

    cfg_state_e  state_q;
    cfg_state_e  state_d;
    logic [3:0]  index_q;
    logic [1:0]  byte_cnt_q;
    logic [15:0] gap_q;
    logic [7:0]  byte_q;
    logic        cmd_start_q;
    logic        cmd_stop_q;
    logic [7:0]  mux_byte;
    logic        mux_start;
    logic        mux_stop;
    logic        start_ok;
    logic        ack_ok;
    logic        last_byte;
    logic        gap_end;

`ifdef CODEC_CFG_RETRY_EN
    localparam logic [7:0] RETRY_CAP = 8'(MAX_RETRIES);
    logic [7:0] retry_q;
    logic       failed_q;
    logic       ack_retry;
`endif

    codec_cfg_byte_mux #(
        .DEV_ADDR(DEV_ADDR)
    ) u_mux (
        .index    (index_q),
        .byte_sel (byte_cnt_q),
        .byte_out (mux_byte),
        .cmd_start(mux_start),
        .cmd_stop (mux_stop)
    );

    assign start_ok  = i_START &&
                       (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign ack_ok    = (state_q == ST_WAIT_ACK) && i_ACK && !i_NACK;
    assign last_byte = (byte_cnt_q == 2'd2);
    assign gap_end   = (gap_q == 16'd0);

`ifdef CODEC_CFG_RETRY_EN
    assign ack_retry = (state_q == ST_WAIT_ACK) && i_ACK && i_NACK &&
                       (retry_q != RETRY_CAP);
`endif

    // State register; reset aborts any transaction at once.
    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_START) state_d = ST_LOAD;
            end
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (i_ACK) begin
                    if (!i_NACK) begin
                        state_d = last_byte ? ST_GAP : ST_LOAD;
                    end else begin
`ifdef CODEC_CFG_RETRY_EN
                        state_d = (retry_q == RETRY_CAP) ? ST_ERROR : ST_GAP;
`else
                        state_d = ST_ERROR;
`endif
                    end
                end
            end
            ST_GAP: begin
                if (gap_end) begin
`ifdef CODEC_CFG_RETRY_EN
                    if (failed_q)                 state_d = ST_LOAD;
                    else if (index_q == LAST_IDX) state_d = ST_DONE;
                    else                          state_d = ST_LOAD;
`else
                    if (index_q == LAST_IDX) state_d = ST_DONE;
                    else                     state_d = ST_LOAD;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        o_REQ         = state_q inside {ST_SEND, ST_WAIT_ACK};
        o_BUSY        = state_q inside {ST_LOAD, ST_SEND, ST_WAIT_ACK, ST_GAP};
        o_CODEC_READY = (state_q == ST_DONE);
        o_ERROR       = (state_q == ST_ERROR);
    end

    assign o_BYTE      = byte_q;
    assign o_CMD_START = cmd_start_q;
    assign o_CMD_STOP  = cmd_stop_q;
    assign o_INDEX     = index_q;

    // Index, byte position, gap timer and the held byte/flags.
    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            index_q     <= 4'd0;
            byte_cnt_q  <= 2'd0;
            gap_q       <= 16'd0;
            byte_q      <= 8'h00;
            cmd_start_q <= 1'b0;
            cmd_stop_q  <= 1'b0;
`ifdef CODEC_CFG_RETRY_EN
            retry_q     <= 8'd0;
            failed_q    <= 1'b0;
`endif
        end else begin
            if (start_ok) begin
                index_q    <= 4'd0;
                byte_cnt_q <= 2'd0;
`ifdef CODEC_CFG_RETRY_EN
                retry_q    <= 8'd0;
                failed_q   <= 1'b0;
`endif
            end
            if (state_q == ST_LOAD) begin
                byte_q      <= mux_byte;
                cmd_start_q <= mux_start;
                cmd_stop_q  <= mux_stop;
            end
            if (ack_ok) begin
                if (last_byte) begin
                    gap_q   <= GAP_CYCLES - 16'd1;
`ifdef CODEC_CFG_RETRY_EN
                    retry_q <= 8'd0;
`endif
                end else begin
                    byte_cnt_q <= byte_cnt_q + 2'd1;
                end
            end
`ifdef CODEC_CFG_RETRY_EN
            if (ack_retry) begin
                gap_q    <= GAP_CYCLES - 16'd1;
                failed_q <= 1'b1;
                retry_q  <= retry_q + 8'd1;
            end
`endif
            if (state_q == ST_GAP) begin
                if (!gap_end) begin
                    gap_q <= gap_q - 16'd1;
                end else begin
                    byte_cnt_q <= 2'd0;
`ifdef CODEC_CFG_RETRY_EN
                    failed_q <= 1'b0;
                    if (!failed_q && index_q != LAST_IDX)
                        index_q <= index_q + 4'd1;
`else
                    if (index_q != LAST_IDX)
                        index_q <= index_q + 4'd1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Directed bench for codec_config_sequencer (GAP_CYCLES=4).
// Covers both builds of CODEC_CFG_RETRY_EN.
module tb_codec_config_sequencer;

    logic       clk = 1'b0;
    logic       i_NRESET = 1'b0;
    logic       i_START = 1'b0;
    logic       i_ACK = 1'b0;
    logic       i_NACK = 1'b0;
    logic       o_REQ;
    logic       o_CMD_START;
    logic       o_CMD_STOP;
    logic [7:0] o_BYTE;
    logic       o_BUSY;
    logic       o_CODEC_READY;
    logic       o_ERROR;
    logic [3:0] o_INDEX;

    int n_tests = 0;
    int n_fail  = 0;
    int unstable = 0;

    logic [6:0] exp_reg [9] = '{7'd15, 7'd2, 7'd3, 7'd4, 7'd5,
                                7'd6, 7'd7, 7'd8, 7'd9};
    logic [8:0] exp_dat [9] = '{9'h000, 9'h079, 9'h079, 9'h010, 9'h000,
                                9'h067, 9'h002, 9'h000, 9'h001};

    logic [7:0] got   [27];
    logic [1:0] gotf  [27];
    logic [3:0] goti  [27];
    int         waits [27];

    logic [7:0] b;
    logic [1:0] f;
    logic [3:0] ix;
    int         w;

    codec_config_sequencer #(
        .GAP_CYCLES(16'd4)
    ) dut (
        .i_CLK        (clk),
        .i_NRESET     (i_NRESET),
        .i_START      (i_START),
        .o_REQ        (o_REQ),
        .o_CMD_START  (o_CMD_START),
        .o_CMD_STOP   (o_CMD_STOP),
        .o_BYTE       (o_BYTE),
        .i_ACK        (i_ACK),
        .i_NACK       (i_NACK),
        .o_BUSY       (o_BUSY),
        .o_CODEC_READY(o_CODEC_READY),
        .o_ERROR      (o_ERROR),
        .o_INDEX      (o_INDEX)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_byte(input int idx, input int pos);
        logic [6:0] r;
        logic [8:0] d;
        r = exp_reg[idx];
        d = exp_dat[idx];
        if (pos == 0)      return 8'h34;
        else if (pos == 1) return {r, d[8]};
        else               return d[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Engine model: wait for o_REQ, hold for dly cycles, then ACK/NACK.
    task automatic serve(input int dly, input logic nack,
                         output logic [7:0] ob, output logic [1:0] of,
                         output logic [3:0] oi, output int waited);
        int t;
        t = 0;
        ob = 8'h00;
        of = 2'b00;
        oi = 4'd0;
        while (o_REQ !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        waited = t;
        chk("req_seen", {31'd0, o_REQ}, 32'd1);
        if (o_REQ !== 1'b1) return;
        ob = o_BYTE;
        of = {o_CMD_START, o_CMD_STOP};
        oi = o_INDEX;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            if (o_REQ !== 1'b1 || o_BYTE !== ob ||
                {o_CMD_START, o_CMD_STOP} !== of) unstable++;
        end
        i_ACK  = 1'b1;
        i_NACK = nack;
        @(negedge clk);
        i_ACK  = 1'b0;
        i_NACK = 1'b0;
    endtask

    task automatic serve_clean(input int from, input int upto);
        for (int k = from; k < upto; k++) begin
            serve(1, 1'b0, b, f, ix, w);
            chk("seq_byte", {24'd0, b}, {24'd0, exp_byte(k / 3, k % 3)});
        end
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (o_CODEC_READY !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ready_reached", {31'd0, o_CODEC_READY}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outs",
            {17'd0, o_REQ, o_CMD_START, o_CMD_STOP, o_BYTE,
             o_BUSY, o_CODEC_READY, o_ERROR, o_INDEX}, 32'd0);
        i_NRESET = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", {31'd0, o_BUSY}, 32'd0);

        // Start latency: LOAD then SEND.
        i_START = 1'b1;
        @(negedge clk);
        i_START = 1'b0;
        chk("load_busy", {31'd0, o_BUSY}, 32'd1);
        chk("load_noreq", {31'd0, o_REQ}, 32'd0);
        @(negedge clk);
        chk("send_req", {31'd0, o_REQ}, 32'd1);

        // Clean run; a START pulse mid-run must be ignored.
        for (int k = 0; k < 27; k++) begin
            if (k == 10) begin
                i_START = 1'b1;
                @(negedge clk);
                i_START = 1'b0;
            end
            serve(1, 1'b0, b, f, ix, w);
            got[k]   = b;
            gotf[k]  = f;
            goti[k]  = ix;
            waits[k] = w;
        end
        for (int k = 0; k < 27; k++) begin
            chk("run_byte", {24'd0, got[k]},
                {24'd0, exp_byte(k / 3, k % 3)});
            chk("run_flags", {30'd0, gotf[k]},
                {30'd0, (k % 3 == 0), (k % 3 == 2)});
            chk("run_index", {28'd0, goti[k]}, k / 3);
        end
        chk("first_b0", {24'd0, got[0]}, 32'h34);
        chk("first_b1", {24'd0, got[1]}, 32'h1E);
        chk("last_b1", {24'd0, got[25]}, 32'h12);
        chk("last_b2", {24'd0, got[26]}, 32'h01);
        chk("intra_gap", waits[1], 1);
        chk("inter_gap", waits[3], 5);

        // Final GAP: four counts, READY and BUSY swap on the same edge.
        repeat (3) @(negedge clk);
        chk("gap_ready0", {31'd0, o_CODEC_READY}, 32'd0);
        chk("gap_busy1", {31'd0, o_BUSY}, 32'd1);
        @(negedge clk);
        chk("done_ready", {31'd0, o_CODEC_READY}, 32'd1);
        chk("done_busy", {31'd0, o_BUSY}, 32'd0);
        chk("done_index", {28'd0, o_INDEX}, 32'd8);
        chk("done_req", {31'd0, o_REQ}, 32'd0);

        // Restart from DONE.
        i_START = 1'b1;
        @(negedge clk);
        i_START = 1'b0;
        chk("restart_ready", {31'd0, o_CODEC_READY}, 32'd0);
        chk("restart_busy", {31'd0, o_BUSY}, 32'd1);
        chk("restart_index", {28'd0, o_INDEX}, 32'd0);

        // Slow engine: 50-cycle ACK delay.
        unstable = 0;
        serve(50, 1'b0, b, f, ix, w);
        chk("slow_stable", unstable, 0);
        chk("slow_byte", {24'd0, b}, 32'h34);

        // Reset while waiting on byte 1.
        w = 0;
        while (o_REQ !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        chk("no_dup_byte", {24'd0, o_BYTE}, 32'h1E);
        chk("wait_req", {31'd0, o_REQ}, 32'd1);
        i_NRESET = 1'b0;
        #1;
        chk("async_reset",
            {17'd0, o_REQ, o_CMD_START, o_CMD_STOP, o_BYTE,
             o_BUSY, o_CODEC_READY, o_ERROR, o_INDEX}, 32'd0);
        @(negedge clk);
        i_NRESET = 1'b1;
        @(negedge clk);

        // Fresh run; NACK on byte 1 of index 3.
        i_START = 1'b1;
        @(negedge clk);
        i_START = 1'b0;
        serve_clean(0, 10);
        serve(1, 1'b1, b, f, ix, w);
        chk("nack_byte", {24'd0, b}, 32'h08);
        chk("nack_index", {28'd0, ix}, 32'd3);
`ifdef CODEC_CFG_RETRY_EN
        chk("nack_no_err", {31'd0, o_ERROR}, 32'd0);
        chk("nack_busy", {31'd0, o_BUSY}, 32'd1);
        serve(1, 1'b0, b, f, ix, w);
        chk("retry_b0", {24'd0, b}, 32'h34);
        chk("retry_idx", {28'd0, ix}, 32'd3);
        serve(1, 1'b0, b, f, ix, w);
        chk("retry_b1", {24'd0, b}, 32'h08);
        serve(1, 1'b0, b, f, ix, w);
        chk("retry_b2", {24'd0, b}, 32'h10);
        serve_clean(12, 27);
        wait_ready();
        chk("retry_done_busy", {31'd0, o_BUSY}, 32'd0);
`else
        chk("nack_err", {31'd0, o_ERROR}, 32'd1);
        chk("nack_busy", {31'd0, o_BUSY}, 32'd0);
        chk("nack_ready", {31'd0, o_CODEC_READY}, 32'd0);
        chk("nack_req", {31'd0, o_REQ}, 32'd0);
`endif

        // Consecutive NACKs at index 0.
        i_START = 1'b1;
        @(negedge clk);
        i_START = 1'b0;
        chk("nack4_start_err", {31'd0, o_ERROR}, 32'd0);
`ifdef CODEC_CFG_RETRY_EN
        for (int n = 0; n < 4; n++) begin
            serve(1, 1'b1, b, f, ix, w);
            chk("nack4_byte", {24'd0, b}, 32'h34);
            chk("nack4_err", {31'd0, o_ERROR}, (n == 3) ? 32'd1 : 32'd0);
        end
`else
        serve(1, 1'b1, b, f, ix, w);
        chk("nack1_byte", {24'd0, b}, 32'h34);
        chk("nack1_err", {31'd0, o_ERROR}, 32'd1);
`endif
        chk("err_busy", {31'd0, o_BUSY}, 32'd0);

        // Stray ACK in ERROR is ignored.
        i_ACK = 1'b1;
        @(negedge clk);
        i_ACK = 1'b0;
        @(negedge clk);
        chk("stray_ack", {30'd0, o_ERROR, o_REQ}, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/codec_config_sequencer.md
# codec_config_sequencer

Sequences the audio codec's power-up register configuration over the shared I2C byte engine. It walks a fixed table of 9-bit codec register writes and issues each write as a three-byte I2C transaction through a request/acknowledge handshake. When the table completes, it raises a ready flag that gates the I2S transmitter and unmute. It sits between the top-level audio control block and the byte-level I2C master.

## Interface
Parameters:
- DEV_ADDR, 7'h1A: codec 7-bit I2C slave address.
- NUM_REGS, 9: number of table entries written; range 1..16.
- GAP_CYCLES, 16'd1000: idle i_CLK cycles after each register write; range 1..65535.
- MAX_RETRIES, 3: NACK retries per register; used only with retry compiled in.

Ports:
- i_CLK  in  1  system clock.
- i_NRESET  in  1  asynchronous, active-low reset.
- i_START  in  1  single-cycle pulse that begins configuration.
- o_REQ  out  1  byte request to the I2C engine.
- o_CMD_START  out  1  generate an I2C START before this byte; valid with o_REQ.
- o_CMD_STOP  out  1  generate an I2C STOP after this byte; valid with o_REQ.
- o_BYTE  out  8  byte to send; valid with o_REQ.
- i_ACK  in  1  single-cycle pulse: the engine has finished the byte.
- i_NACK  in  1  slave NACKed; sampled only when i_ACK=1.
- o_BUSY  out  1  high from START acceptance until DONE or ERROR.
- o_CODEC_READY  out  1  high in DONE only.
- o_ERROR  out  1  high in ERROR only.
- o_INDEX  out  4  current table index.

## Operation
- States: IDLE, LOAD, SEND, WAIT_ACK, GAP, DONE, ERROR.
- IDLE/DONE/ERROR + i_START:
  - Index←0, retry←0, byte←0.
  - Go to LOAD.
  - i_START is ignored in all other states.
- LOAD: form the byte from table[index] and byte counter.
  - Byte 0: {DEV_ADDR,1'b0}, with CMD_START=1.
  - Byte 1: {reg[6:0],data[8]}.
  - Byte 2: data[7:0], with CMD_STOP=1.
  - Go to SEND.
- SEND: assert o_REQ and go to WAIT_ACK.
- WAIT_ACK:
  - o_REQ, o_BYTE and the CMD flags stay stable until i_ACK.
  - i_ACK with no NACK on byte 0 or 1: byte++, go to LOAD.
  - i_ACK with no NACK on byte 2: go to GAP.
  - o_REQ deasserts the cycle after i_ACK.
- On NACK, the engine issues STOP itself; the sequencer sends no further bytes of that write.
- GAP:
  - Count GAP_CYCLES.
  - If the write succeeded and index==NUM_REGS-1: go to DONE.
  - Else if the write succeeded: index++, byte←0, go to LOAD.
- Table order (reg:data):
  - R15:0x000 (reset)
  - R2:0x079 and R3:0x079 (headphone 0 dB)
  - R4:0x010 (DAC select)
  - R5:0x000 (unmute)
  - R6:0x067 (ADC/mic/line power-down)
  - R7:0x002 (I2S, 16-bit, slave)
  - R8:0x000 (normal, 256fs)
  - R9:0x001 (active)
- An i_ACK pulse outside WAIT_ACK is ignored.

## Timing
- Reset values: all outputs 0, o_BYTE=8'h00, state IDLE.
- Reset mid-transaction aborts immediately. The engine must also be reset.
- i_START to first o_REQ: 2 cycles (LOAD, then SEND).
- i_ACK to next o_REQ within a write: 2 cycles.
- Final i_ACK to the next write's o_REQ: GAP_CYCLES+2 cycles.
- o_CODEC_READY rises the cycle after the last GAP count.
- o_BUSY falls in the same cycle that o_CODEC_READY or o_ERROR rises.
- Gap counter is 16-bit, loaded with GAP_CYCLES-1, and exits at 0.

## Configuration
- CODEC_CFG_RETRY_EN defined:
  - A NACK goes to GAP, then restarts the same index at byte 0 with retry++.
  - A NACK when retry==MAX_RETRIES goes to ERROR.
  - The retry counter clears on every successful write.
- CODEC_CFG_RETRY_EN undefined:
  - Any NACK goes directly to ERROR.
  - No retry counter is synthesized.

## Structure
- Package codec_cfg_pkg contains:
  - Typedef codec_reg_t (7-bit address + 9-bit data).
  - Constant array CODEC_CFG_TABLE[16] (unused entries: R15:0x000).
  - Typedef cfg_state_e.
  - Constant CODEC_I2C_ADDR=7'h1A.
- Sub-module codec_cfg_byte_mux (combinational): index/byte counter → o_BYTE and CMD flags.
- All other logic lives in the top FSM.

## Test plan
- Clean run, GAP_CYCLES=4, slave model ACKs every byte:
  - 27 bytes observed.
  - First three bytes: 0x34 (CMD_START), 0x1E, 0x00 (CMD_STOP).
  - Last three bytes: 0x34, 0x12, 0x01.
  - o_CODEC_READY=1 and o_BUSY=0 at the end.
- Engine delays i_ACK by 50 cycles: o_REQ and o_BYTE remain stable the whole time, and no duplicate bytes are sent.
- NACK on byte 1 of index 3, retry compiled in:
  - Sequence resumes with 0x34, 0x08, 0x10 for index 3.
  - Run completes.
- Four consecutive NACKs at index 0:
  - With retry: o_ERROR=1 after the 4th NACK.
  - Without retry: o_ERROR=1 after the 1st NACK.
- i_START pulsed mid-run is ignored. i_START in DONE restarts from index 0 and drops o_CODEC_READY.
- i_NRESET asserted during WAIT_ACK: all outputs 0 the same cycle. A later i_START runs from index 0.
